// File: rtl/mem_load_unit_pkg.sv
// Shared widths and load-op encoding for the memory load unit.
// The one-hot load op is ordered {lw,lb,lbu,lh,lhu,lwl,lwr}, MSB first.
package mem_load_unit_pkg;

   localparam int DATA_W  = 32;
   localparam int RF_WE_W = 4;
   localparam int LD_OP_W = 7;

   localparam int LD_LW  = 6;
   localparam int LD_LB  = 5;
   localparam int LD_LBU = 4;
   localparam int LD_LH  = 3;
   localparam int LD_LHU = 2;
   localparam int LD_LWL = 1;
   localparam int LD_LWR = 0;

   localparam logic [LD_OP_W-1:0] LD_OP_NONE = 7'b000_0000;
   localparam logic [LD_OP_W-1:0] LD_OP_LW   = 7'b100_0000;
   localparam logic [LD_OP_W-1:0] LD_OP_LB   = 7'b010_0000;
   localparam logic [LD_OP_W-1:0] LD_OP_LBU  = 7'b001_0000;
   localparam logic [LD_OP_W-1:0] LD_OP_LH   = 7'b000_1000;
   localparam logic [LD_OP_W-1:0] LD_OP_LHU  = 7'b000_0100;
   localparam logic [LD_OP_W-1:0] LD_OP_LWL  = 7'b000_0010;
   localparam logic [LD_OP_W-1:0] LD_OP_LWR  = 7'b000_0001;

   // Sign- or zero-extend a byte (v[7:0]) or a halfword (v[15:0]) to a full word.
   function automatic logic [DATA_W-1:0] ld_extend(input logic [15:0] v,
                                                    input logic is_half,
                                                    input logic is_signed);
      logic [DATA_W-1:0] w;
      if (is_half) begin
         w = {{16{is_signed & v[15]}}, v};
      end else begin
         w = {{24{is_signed & v[7]}}, v[7:0]};
      end
      return w;
   endfunction

endpackage

// File: rtl/mem_load_align.sv
// Combinational load-data extraction and per-byte register write-enable generation.
// Little-endian byte lanes; lwl/lwr produce the partial-word merge enables.
module mem_load_align
   import mem_load_unit_pkg::*;
(
   input  logic [LD_OP_W-1:0] i_ld_op,
   input  logic [1:0]         i_addr,
   input  logic [DATA_W-1:0]  i_rdata,
   input  logic [DATA_W-1:0]  i_alu_result,
   input  logic               i_res_from_mem,
   input  logic               i_gr_we,
   output logic [DATA_W-1:0]  o_result,
   output logic [RF_WE_W-1:0] o_rf_we
);

   logic [DATA_W-1:0] w_shift_r;
   logic [DATA_W-1:0] w_shift_l;
   logic [15:0]       w_half;
   logic [DATA_W-1:0] w_load;

   // Lane selection and extension; 8*(3-addr) equals 8*~addr for a 2-bit address.
   always_comb begin
      w_shift_r = i_rdata >> {i_addr, 3'b000};
      w_shift_l = i_rdata << {~i_addr, 3'b000};
      w_half    = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];
      case (i_ld_op)
         LD_OP_LB:  w_load = ld_extend(w_shift_r[15:0], 1'b0, 1'b1);
         LD_OP_LBU: w_load = ld_extend(w_shift_r[15:0], 1'b0, 1'b0);
         LD_OP_LH:  w_load = ld_extend(w_half, 1'b1, 1'b1);
         LD_OP_LHU: w_load = ld_extend(w_half, 1'b1, 1'b0);
         LD_OP_LWL: w_load = w_shift_l;
         LD_OP_LWR: w_load = w_shift_r;
         default:   w_load = i_rdata;
      endcase
      o_result = i_res_from_mem ? w_load : i_alu_result;
   end

   // Byte write enables; unaligned loads only write the lanes they supply.
   always_comb begin
      if (i_ld_op[LD_LWL]) begin
         o_rf_we = {1'b1, i_addr != 2'd0, i_addr[1], i_addr == 2'd3};
      end else if (i_ld_op[LD_LWR]) begin
         o_rf_we = {i_addr == 2'd0, ~i_addr[1], i_addr != 2'd3, 1'b1};
      end else begin
         o_rf_we = {RF_WE_W{i_gr_we}};
      end
   end

endmodule

// File: rtl/mem_load_unit.sv
// In-order queue of memory-stage entries awaiting bus responses, with flush
// cancellation of responses still in flight and a zero-bubble head bypass.
module mem_load_unit
   import mem_load_unit_pkg::*;
#(
   parameter int DEPTH  = 2,
   parameter int DEST_W = 5
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_allowin,
   input  logic                       in_mem,
   input  logic [LD_OP_W-1:0]         in_ld_op,
   input  logic                       in_res_from_mem,
   input  logic                       in_gr_we,
   input  logic [DEST_W-1:0]          in_dest,
   input  logic [DATA_W-1:0]          in_alu_result,
   input  logic [DATA_W-1:0]          in_pc,
   input  logic                       data_ok,
   input  logic [DATA_W-1:0]          rdata,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [RF_WE_W-1:0]         out_rf_we,
   output logic [DEST_W-1:0]          out_dest,
   output logic [DATA_W-1:0]          out_result,
   output logic [DATA_W-1:0]          out_pc,
   output logic [$clog2(DEPTH+1)-1:0] out_pending
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int CAN_W = $clog2(DEPTH + 2);

   logic                r_mem          [DEPTH];
   logic                r_done         [DEPTH];
   logic [LD_OP_W-1:0]  r_ld_op        [DEPTH];
   logic                r_res_from_mem [DEPTH];
   logic                r_gr_we        [DEPTH];
   logic [DEST_W-1:0]   r_dest         [DEPTH];
   logic [DATA_W-1:0]   r_alu          [DEPTH];
   logic [DATA_W-1:0]   r_pc           [DEPTH];
   logic [DATA_W-1:0]   r_rdata        [DEPTH];

   logic [PTR_W-1:0]    r_head;
   logic [PTR_W-1:0]    r_tail;
   logic [CNT_W-1:0]    r_count;
   logic [CAN_W-1:0]    r_cancel;

   logic [PTR_W-1:0]    w_idx;
   logic [PTR_W-1:0]    w_wait_idx;
   logic                w_wait_found;
   logic [CNT_W-1:0]    w_pending;
   logic                w_bind;
   logic                w_head_done;
   logic                w_push;
   logic                w_pop;
   logic [DATA_W-1:0]   w_head_rdata;
   logic [RF_WE_W-1:0]  w_rf_we;
   int                  w_cancel_calc;
   logic [CAN_W-1:0]    w_cancel_nxt;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(DEPTH - 1)) begin
         return '0;
      end else begin
         return p + PTR_W'(1);
      end
   endfunction

   // Scan from head for the oldest held entry still waiting on its response.
   always_comb begin
      w_wait_found = 1'b0;
      w_wait_idx   = '0;
      w_pending    = '0;
      w_idx        = r_head;
      for (int i = 0; i < DEPTH; i++) begin
         if ((i < int'(r_count)) && r_mem[w_idx] && !r_done[w_idx]) begin
            w_pending = w_pending + CNT_W'(1);
            if (!w_wait_found) begin
               w_wait_found = 1'b1;
               w_wait_idx   = w_idx;
            end else begin
               w_wait_found = 1'b1;
            end
         end else begin
            w_pending = w_pending;
         end
         w_idx = ptr_inc(w_idx);
      end
   end

   // Handshake and head presentation; a head completed this cycle uses live rdata.
   always_comb begin
      w_bind       = data_ok && (r_cancel == '0) && w_wait_found;
      w_head_done  = (r_count != '0) &&
                     (r_done[r_head] || (w_bind && (w_wait_idx == r_head)));
      out_valid    = w_head_done && !flush;
      w_pop        = out_valid && out_ready;
      in_allowin   = (r_count < CNT_W'(DEPTH)) || w_pop;
      w_push       = in_valid && in_allowin && !flush;
      w_head_rdata = r_done[r_head] ? r_rdata[r_head] : rdata;
      out_rf_we    = out_valid ? w_rf_we : '0;
      out_dest     = r_dest[r_head];
      out_pc       = r_pc[r_head];
      out_pending  = w_pending;
   end

   // Responses owed to flushed requests; each is discarded as it returns.
   always_comb begin
      w_cancel_calc = int'(r_cancel);
      if (data_ok && (r_cancel != '0)) begin
         w_cancel_calc = w_cancel_calc - 1;
      end else begin
         w_cancel_calc = w_cancel_calc;
      end
      if (flush) begin
         w_cancel_calc = w_cancel_calc + int'(w_pending) + int'(in_valid && in_mem)
                         - int'(w_bind);
      end else begin
         w_cancel_calc = w_cancel_calc;
      end
      w_cancel_nxt = CAN_W'(w_cancel_calc);
   end

   mem_load_align u_align (
      .i_ld_op        (r_ld_op[r_head]),
      .i_addr         (r_alu[r_head][1:0]),
      .i_rdata        (w_head_rdata),
      .i_alu_result   (r_alu[r_head]),
      .i_res_from_mem (r_res_from_mem[r_head]),
      .i_gr_we        (r_gr_we[r_head]),
      .o_result       (out_result),
      .o_rf_we        (w_rf_we)
   );

   // Queue pointers, occupancy and cancel counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_head   <= '0;
         r_tail   <= '0;
         r_count  <= '0;
         r_cancel <= '0;
      end else if (flush) begin
         r_head   <= '0;
         r_tail   <= '0;
         r_count  <= '0;
         r_cancel <= w_cancel_nxt;
      end else begin
         r_head   <= w_pop  ? ptr_inc(r_head) : r_head;
         r_tail   <= w_push ? ptr_inc(r_tail) : r_tail;
         r_count  <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
         r_cancel <= w_cancel_nxt;
      end
   end

   // Slot payload; a push into a slot freed this cycle overrides its response capture.
   always_ff @(posedge clk) begin
      if (w_bind) begin
         r_done[w_wait_idx]  <= 1'b1;
         r_rdata[w_wait_idx] <= rdata;
      end
      if (w_push) begin
         r_mem[r_tail]          <= in_mem;
         r_done[r_tail]         <= !in_mem;
         r_ld_op[r_tail]        <= in_ld_op;
         r_res_from_mem[r_tail] <= in_res_from_mem;
         r_gr_we[r_tail]        <= in_gr_we;
         r_dest[r_tail]         <= in_dest;
         r_alu[r_tail]          <= in_alu_result;
         r_pc[r_tail]           <= in_pc;
      end
   end

endmodule

// File: tb/tb_mem_load_unit.sv
// Directed bench for mem_load_unit (DEPTH=2): inputs change 1ns after the
// rising edge, outputs are checked on the falling edge.
module tb_mem_load_unit;
   import mem_load_unit_pkg::*;

   logic        clk;
   logic        reset;
   logic        flush;
   logic        in_valid;
   logic        in_allowin;
   logic        in_mem;
   logic [6:0]  in_ld_op;
   logic        in_res_from_mem;
   logic        in_gr_we;
   logic [4:0]  in_dest;
   logic [31:0] in_alu_result;
   logic [31:0] in_pc;
   logic        data_ok;
   logic [31:0] rdata;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  out_rf_we;
   logic [4:0]  out_dest;
   logic [31:0] out_result;
   logic [31:0] out_pc;
   logic [1:0]  out_pending;

   int n_total = 0;
   int n_bad   = 0;

   mem_load_unit #(.DEPTH(2), .DEST_W(5)) dut (
      .clk             (clk),
      .reset           (reset),
      .flush           (flush),
      .in_valid        (in_valid),
      .in_allowin      (in_allowin),
      .in_mem          (in_mem),
      .in_ld_op        (in_ld_op),
      .in_res_from_mem (in_res_from_mem),
      .in_gr_we        (in_gr_we),
      .in_dest         (in_dest),
      .in_alu_result   (in_alu_result),
      .in_pc           (in_pc),
      .data_ok         (data_ok),
      .rdata           (rdata),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_rf_we       (out_rf_we),
      .out_dest        (out_dest),
      .out_result      (out_result),
      .out_pc          (out_pc),
      .out_pending     (out_pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic mem, input logic [6:0] op, input logic rfm,
                         input logic [4:0] dest, input logic [31:0] alu,
                         input logic [31:0] pc);
      in_valid        = 1'b1;
      in_mem          = mem;
      in_ld_op        = op;
      in_res_from_mem = rfm;
      in_gr_we        = 1'b1;
      in_dest         = dest;
      in_alu_result   = alu;
      in_pc           = pc;
   endtask

   initial begin
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_mem = 1'b0;
      in_ld_op = 7'd0; in_res_from_mem = 1'b0; in_gr_we = 1'b0; in_dest = 5'd0;
      in_alu_result = 32'd0; in_pc = 32'd0; data_ok = 1'b0; rdata = 32'd0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;

      @(negedge clk);
      chk("rst_valid",   32'(out_valid),   32'd0);
      chk("rst_rf_we",   32'(out_rf_we),   32'd0);
      chk("rst_pending", 32'(out_pending), 32'd0);
      chk("rst_allowin", 32'(in_allowin),  32'd1);
      step();

      // lb addr=2, response arrives while head
      set_in(1'b1, LD_OP_LB, 1'b1, 5'd3, 32'h0000_1002, 32'h0000_0100);
      out_ready = 1'b1;
      @(negedge clk);
      chk("lb_allowin", 32'(in_allowin), 32'd1);
      step();
      in_valid = 1'b0; data_ok = 1'b1; rdata = 32'h80FF_1234;
      @(negedge clk);
      chk("lb_valid",   32'(out_valid),   32'd1);
      chk("lb_result",  out_result,       32'hFFFF_FFFF);
      chk("lb_rf_we",   32'(out_rf_we),   32'hF);
      chk("lb_dest",    32'(out_dest),    32'd3);
      chk("lb_pc",      out_pc,           32'h0000_0100);
      chk("lb_pending", 32'(out_pending), 32'd1);
      step();
      data_ok = 1'b0;
      @(negedge clk);
      chk("lb_done_valid",   32'(out_valid),   32'd0);
      chk("lb_done_pending", 32'(out_pending), 32'd0);
      step();

      // lwl addr=1 (bypass then stored), lwr addr=2
      set_in(1'b1, LD_OP_LWL, 1'b1, 5'd1, 32'h0000_0401, 32'h0000_0200);
      out_ready = 1'b0;
      step();
      in_valid = 1'b0; data_ok = 1'b1; rdata = 32'hAABB_CCDD;
      @(negedge clk);
      chk("lwl_valid",  32'(out_valid), 32'd1);
      chk("lwl_result", out_result,     32'hCCDD_0000);
      chk("lwl_rf_we",  32'(out_rf_we), 32'hC);
      step();
      data_ok = 1'b0; rdata = 32'h0; out_ready = 1'b1;
      @(negedge clk);
      chk("lwl_st_valid",  32'(out_valid), 32'd1);
      chk("lwl_st_result", out_result,     32'hCCDD_0000);
      chk("lwl_st_rf_we",  32'(out_rf_we), 32'hC);
      step();
      set_in(1'b1, LD_OP_LWR, 1'b1, 5'd2, 32'h0000_0402, 32'h0000_0204);
      step();
      in_valid = 1'b0; data_ok = 1'b1; rdata = 32'hAABB_CCDD;
      @(negedge clk);
      chk("lwr_result", out_result,     32'h0000_AABB);
      chk("lwr_rf_we",  32'(out_rf_we), 32'h3);
      step();
      data_ok = 1'b0;

      // back-to-back loads, full queue, late out_ready, push+pop when full
      out_ready = 1'b0;
      set_in(1'b1, LD_OP_LW, 1'b1, 5'd5, 32'h0000_0200, 32'h0000_0010);
      step();
      set_in(1'b1, LD_OP_LHU, 1'b1, 5'd6, 32'h0000_0202, 32'h0000_0014);
      step();
      set_in(1'b0, LD_OP_NONE, 1'b0, 5'd7, 32'hDEAD_BEEF, 32'h0000_0018);
      data_ok = 1'b1; rdata = 32'h1111_2222;
      @(negedge clk);
      chk("b2b_c3_allowin", 32'(in_allowin), 32'd0);
      chk("b2b_c3_valid",   32'(out_valid),  32'd1);
      chk("b2b_c3_result",  out_result,      32'h1111_2222);
      step();
      rdata = 32'h3333_ABCD;
      @(negedge clk);
      chk("b2b_c4_allowin", 32'(in_allowin), 32'd0);
      chk("b2b_c4_result",  out_result,      32'h1111_2222);
      step();
      data_ok = 1'b0;
      @(negedge clk);
      chk("b2b_c5_pending", 32'(out_pending), 32'd0);
      chk("b2b_c5_allowin", 32'(in_allowin),  32'd0);
      step();
      out_ready = 1'b1;
      @(negedge clk);
      chk("b2b_c6_allowin", 32'(in_allowin), 32'd1);
      chk("b2b_c6_result",  out_result,      32'h1111_2222);
      chk("b2b_c6_dest",    32'(out_dest),   32'd5);
      step();
      in_valid = 1'b0;
      @(negedge clk);
      chk("b2b_c7_valid",  32'(out_valid), 32'd1);
      chk("b2b_c7_result", out_result,     32'h0000_3333);
      chk("b2b_c7_dest",   32'(out_dest),  32'd6);
      step();
      @(negedge clk);
      chk("b2b_c8_result", out_result,     32'hDEAD_BEEF);
      chk("b2b_c8_dest",   32'(out_dest),  32'd7);
      chk("b2b_c8_rf_we",  32'(out_rf_we), 32'hF);
      step();
      @(negedge clk);
      chk("b2b_c9_valid", 32'(out_valid), 32'd0);
      step();

      // ALU entry held behind a waiting load
      set_in(1'b1, LD_OP_LW, 1'b1, 5'd13, 32'h0000_0500, 32'h0000_0060);
      step();
      set_in(1'b0, LD_OP_NONE, 1'b0, 5'd14, 32'hCAFE_F00D, 32'h0000_0064);
      @(negedge clk);
      chk("ord_c2_valid", 32'(out_valid), 32'd0);
      step();
      in_valid = 1'b0;
      @(negedge clk);
      chk("ord_c3_valid",   32'(out_valid),   32'd0);
      chk("ord_c3_pending", 32'(out_pending), 32'd1);
      step();
      data_ok = 1'b1; rdata = 32'h1234_5678;
      @(negedge clk);
      chk("ord_c4_result", out_result,    32'h1234_5678);
      chk("ord_c4_dest",   32'(out_dest), 32'd13);
      step();
      data_ok = 1'b0;
      @(negedge clk);
      chk("ord_c5_valid",  32'(out_valid), 32'd1);
      chk("ord_c5_result", out_result,     32'hCAFE_F00D);
      chk("ord_c5_dest",   32'(out_dest),  32'd14);
      step();
      @(negedge clk);
      chk("ord_c6_valid", 32'(out_valid), 32'd0);
      step();

      // flush with two waiting loads, then two stale responses
      set_in(1'b1, LD_OP_LW, 1'b1, 5'd8, 32'h0000_0300, 32'h0000_0040);
      step();
      set_in(1'b1, LD_OP_LW, 1'b1, 5'd9, 32'h0000_0304, 32'h0000_0044);
      step();
      in_valid = 1'b0; flush = 1'b1;
      @(negedge clk);
      chk("fl_valid",   32'(out_valid),   32'd0);
      chk("fl_pending", 32'(out_pending), 32'd2);
      step();
      flush = 1'b0; data_ok = 1'b1; rdata = 32'hBAD0_0001;
      @(negedge clk);
      chk("fl_cancel2", 32'(dut.r_cancel), 32'd2);
      chk("fl_d1_valid",   32'(out_valid),   32'd0);
      chk("fl_d1_pending", 32'(out_pending), 32'd0);
      step();
      rdata = 32'hBAD0_0002;
      set_in(1'b1, LD_OP_LW, 1'b1, 5'd10, 32'h0000_0308, 32'h0000_0048);
      @(negedge clk);
      chk("fl_cancel1",    32'(dut.r_cancel), 32'd1);
      chk("fl_d2_valid",   32'(out_valid),    32'd0);
      chk("fl_d2_allowin", 32'(in_allowin),   32'd1);
      step();
      in_valid = 1'b0; rdata = 32'h0000_C0DE;
      @(negedge clk);
      chk("fl_cancel0", 32'(dut.r_cancel), 32'd0);
      chk("fl_new_valid",  32'(out_valid), 32'd1);
      chk("fl_new_result", out_result,     32'h0000_C0DE);
      chk("fl_new_dest",   32'(out_dest),  32'd10);
      step();
      data_ok = 1'b0;
      @(negedge clk);
      chk("fl_end_valid", 32'(out_valid), 32'd0);
      step();

      // flush coincident with a bound response and an incoming mem entry
      set_in(1'b1, LD_OP_LW, 1'b1, 5'd11, 32'h0000_0310, 32'h0000_0050);
      step();
      set_in(1'b1, LD_OP_LW, 1'b1, 5'd12, 32'h0000_0314, 32'h0000_0054);
      flush = 1'b1; data_ok = 1'b1; rdata = 32'h7777_7777;
      @(negedge clk);
      chk("fc_valid", 32'(out_valid), 32'd0);
      step();
      flush = 1'b0; in_valid = 1'b0; data_ok = 1'b0;
      @(negedge clk);
      chk("fc_cancel1", 32'(dut.r_cancel), 32'd1);
      chk("fc_pending", 32'(out_pending),  32'd0);
      chk("fc_valid2",  32'(out_valid),    32'd0);
      step();
      data_ok = 1'b1; rdata = 32'h9999_9999;
      @(negedge clk);
      chk("fc_stale_valid", 32'(out_valid), 32'd0);
      step();
      data_ok = 1'b0;
      set_in(1'b1, LD_OP_LH, 1'b1, 5'd15, 32'h0000_0312, 32'h0000_0058);
      @(negedge clk);
      chk("fc_cancel0", 32'(dut.r_cancel), 32'd0);
      step();
      in_valid = 1'b0; data_ok = 1'b1; rdata = 32'h8001_7FFF;
      @(negedge clk);
      chk("lh_valid",  32'(out_valid), 32'd1);
      chk("lh_result", out_result,     32'hFFFF_8001);
      chk("lh_rf_we",  32'(out_rf_we), 32'hF);
      step();
      data_ok = 1'b0;

      // reset with a load outstanding
      set_in(1'b1, LD_OP_LW, 1'b1, 5'd16, 32'h0000_0600, 32'h0000_0070);
      step();
      in_valid = 1'b0; reset = 1'b1;
      step();
      reset = 1'b0;
      @(negedge clk);
      chk("mrst_pending", 32'(out_pending),   32'd0);
      chk("mrst_valid",   32'(out_valid),     32'd0);
      chk("mrst_allowin", 32'(in_allowin),    32'd1);
      chk("mrst_cancel",  32'(dut.r_cancel),  32'd0);
      step();

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
